tea_decryptor: RTL
==================

TEA_DECRYPTOR -- requirements
Module: tea_decryptor

Interface
REQ-001 Parameter NUM_ROUNDS, default 32, number of TEA rounds; SHALL be in 1..64 and match the paired encryptor.
REQ-002 Parameter DELTA, default 32'h9E3779B9, TEA key-schedule constant.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_key  input  128  key; k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
REQ-006 i_axis_valid_s  input  1  slave AXI-Stream valid; ciphertext block offered.
REQ-007 o_axis_ready_s  output  1  slave ready; block can be accepted.
REQ-008 i_axis_data_s  input  64  ciphertext; v0=[63:32], v1=[31:0].
REQ-009 o_axis_valid_m  output  1  master valid; plaintext available.
REQ-010 i_axis_ready_m  input  1  downstream ready.
REQ-011 o_axis_data_m  output  64  plaintext; v0=[63:32], v1=[31:0].

Function
REQ-012 The FSM SHALL use 2-bit states IDLE=00, LOADING=01, PROCESSING=10, DONE=11, held in a register named state, with combinational next_state.
REQ-013 o_axis_ready_s SHALL be 1 only in IDLE; o_axis_valid_m SHALL be 1 only in DONE; both SHALL be registered-state decodes.
REQ-014 IDLE: on i_axis_valid_s && o_axis_ready_s, capture i_axis_data_s into v0/v1 and i_key into an internal key register, then go to LOADING; otherwise stay in IDLE.
REQ-015 LOADING: sum SHALL be set to (DELTA*NUM_ROUNDS) mod 2^32 (32'hC6EF3720 at default), round_counter SHALL be cleared to 0, and the FSM SHALL go unconditionally to PROCESSING.
REQ-016 PROCESSING: each cycle performs one round, all mod 2^32:
- v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
- v0 -= ((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1), where v1' is the updated v1
- sum -= DELTA
- round_counter += 1
REQ-017 Shifts SHALL be logical; round_counter SHALL be 6 bits wide.
REQ-018 PROCESSING SHALL go to DONE when round_counter >= NUM_ROUNDS-1, otherwise remain in PROCESSING.
- Transitions SHALL depend only on state, round_counter and handshake signals, never on data or key values.
REQ-019 On entry to DONE, o_axis_data_m SHALL equal {v0,v1}; it SHALL stay stable while o_axis_valid_m=1 and i_axis_ready_m=0.
REQ-020 DONE: on o_axis_valid_m && i_axis_ready_m, go to IDLE; otherwise stay in DONE indefinitely (backpressure).
REQ-021 Latency: o_axis_valid_m SHALL rise exactly NUM_ROUNDS+1 cycles after the input-handshake edge (33 at default).
REQ-022 Throughput: the next input SHALL be accepted no earlier than the cycle after the output handshake; minimum period is NUM_ROUNDS+3 cycles.
REQ-023 Changes on i_key or i_axis_data_s outside the IDLE handshake SHALL NOT affect the block in flight.
REQ-024 i_axis_valid_s asserted outside IDLE SHALL be ignored and SHALL NOT be consumed.
REQ-025 Data SHALL be bit-exact inverse of tea_accelerator for equal key and NUM_ROUNDS.

Reset
REQ-026 When i_rst_n=0, without waiting for a clock edge:
- state=IDLE
- v0, v1, sum, key register, round_counter and o_axis_data_m = 0
- o_axis_valid_m = 0
- o_axis_ready_s SHALL be 1, since it is an IDLE decode
REQ-027 Reset asserted mid-operation (LOADING, PROCESSING or DONE) SHALL abort the block with no output handshake.
REQ-028 After i_rst_n deasserts, the first valid input SHALL be accepted on the first clock edge.

Verification
REQ-029 Key 0, ciphertext 64'h41EA3A0A94BAA940, i_axis_ready_m=1 -> o_axis_data_m=64'h0 with o_axis_valid_m high 33 cycles after the handshake.
REQ-030 Round trip: random key/plaintext through tea_accelerator, then tea_decryptor, 1000 blocks -> output equals the original plaintext every time.
REQ-031 Hold i_axis_ready_m=0 for 10 cycles in DONE, toggling i_key/i_axis_data_s -> valid held at 1, data stable, o_axis_ready_s=0, then release -> IDLE next cycle.
REQ-032 Assert i_rst_n=0 when round_counter=15 -> outputs cleared asynchronously, no o_axis_valid_m pulse, and the next block decodes correctly.
REQ-033 Formal: each state's next_state matches REQ-014/015/018/020 for all data and key values, and o_axis_ready_s && o_axis_valid_m is never 1.
REQ-034 Back-to-back with i_axis_valid_s held at 1 -> accepts spaced exactly 35 cycles apart, with no dropped or duplicated blocks.

Source files
------------

// File: rtl/tea_decryptor.sv
// TEA block decryptor: one round per clock, AXI-Stream style handshakes on both sides.
// Accepts a 64-bit ciphertext with a 128-bit key and returns the plaintext NUM_ROUNDS+1 cycles later.
module tea_decryptor #(
    parameter int          NUM_ROUNDS = 32,
    parameter logic [31:0] DELTA      = 32'h9E3779B9
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [127:0] i_key,
    input  logic         i_axis_valid_s,
    output logic         o_axis_ready_s,
    input  logic [63:0]  i_axis_data_s,
    output logic         o_axis_valid_m,
    input  logic         i_axis_ready_m,
    output logic [63:0]  o_axis_data_m
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        LOADING    = 2'b01,
        PROCESSING = 2'b10,
        DONE       = 2'b11
    } state_t;

    localparam logic [31:0] SUM_INIT   = 32'(64'(DELTA) * 64'(NUM_ROUNDS));
    localparam logic [5:0]  LAST_ROUND = 6'(NUM_ROUNDS - 1);

    state_t         state, next_state;
    logic [31:0]    v0_q, v0_d;
    logic [31:0]    v1_q, v1_d;
    logic [31:0]    sum_q, sum_d;
    logic [127:0]   key_q, key_d;
    logic [5:0]     round_counter_q, round_counter_d;
    logic [63:0]    data_q, data_d;

    logic [31:0]    k0, k1, k2, k3;
    logic [31:0]    v1_round, v0_round;

    assign k0 = key_q[127:96];
    assign k1 = key_q[95:64];
    assign k2 = key_q[63:32];
    assign k3 = key_q[31:0];

    // v0 is undone with the already-updated v1, mirroring the encryptor's order in reverse.
    assign v1_round = v1_q - (((v0_q << 4) + k2) ^ (v0_q + sum_q) ^ ((v0_q >> 5) + k3));
    assign v0_round = v0_q - (((v1_round << 4) + k0) ^ (v1_round + sum_q) ^ ((v1_round >> 5) + k1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state      = state;
        v0_d            = v0_q;
        v1_d            = v1_q;
        sum_d           = sum_q;
        key_d           = key_q;
        round_counter_d = round_counter_q;
        data_d          = data_q;

        case (state)
            IDLE: begin
                if (i_axis_valid_s) begin
                    v0_d       = i_axis_data_s[63:32];
                    v1_d       = i_axis_data_s[31:0];
                    key_d      = i_key;
                    next_state = LOADING;
                end
            end
            LOADING: begin
                sum_d           = SUM_INIT;
                round_counter_d = '0;
                next_state      = PROCESSING;
            end
            PROCESSING: begin
                v0_d            = v0_round;
                v1_d            = v1_round;
                sum_d           = sum_q - DELTA;
                round_counter_d = round_counter_q + 6'd1;
                if (round_counter_q >= LAST_ROUND) begin
                    data_d     = {v0_round, v1_round};
                    next_state = DONE;
                end
            end
            DONE: begin
                if (i_axis_ready_m) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            v0_q            <= '0;
            v1_q            <= '0;
            sum_q           <= '0;
            key_q           <= '0;
            round_counter_q <= '0;
            data_q          <= '0;
        end else begin
            state           <= next_state;
            v0_q            <= v0_d;
            v1_q            <= v1_d;
            sum_q           <= sum_d;
            key_q           <= key_d;
            round_counter_q <= round_counter_d;
            data_q          <= data_d;
        end
    end

    assign o_axis_ready_s = (state == IDLE);
    assign o_axis_valid_m = (state == DONE);
    assign o_axis_data_m  = data_q;

endmodule
